// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED SPI session arbiter.
package oled_pkg;

  localparam int N_REQ_DEFAULT = 3;

  localparam int REQ_INIT  = 0;
  localparam int REQ_CLEAR = 1;
  localparam int REQ_DRAW  = 2;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_e;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic int oh_idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/oled_arb_pick.sv
// Combinational session picker: one-hot winner from the request vector.
// OLED_ARB_RR_EN selects round-robin (search from ptr+1); otherwise lowest index wins.
module oled_arb_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
`ifdef OLED_ARB_RR_EN
  input  logic [$clog2(N_REQ)-1:0] ptr,
`endif
  output logic [N_REQ-1:0]         win
);

`ifdef OLED_ARB_RR_EN
  logic found;
  int   idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + 1 + i) % N_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  // Isolate the lowest set bit.
  assign win = req & (~req + N_REQ'(1));
`endif

endmodule

// File: rtl/oled_spi_arbiter.sv
// Grants exclusive SPI byte-engine sessions to the init/clear/draw jobs.
// OLED_ARB_RR_EN switches the picker from fixed priority to round-robin.
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   job_req,
  output logic [N_REQ-1:0]   job_gnt,
  input  logic [N_REQ-1:0]   req_send,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_dc,
  output logic [N_REQ-1:0]   req_done,
  output logic               spi_send,
  output logic [7:0]         spi_data,
  output logic               spi_dc,
  input  logic               spi_done,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state, state_nx;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    g;
  logic             in_flight, byte_live, hold_shadow;
  logic [7:0]       sh_data;
  logic             sh_dc;

  assign g = PW'(oh_idx(32'(job_gnt)));

`ifdef OLED_ARB_RR_EN
  logic [PW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               rr_ptr <= PW'(N_REQ-1);
    else if (state == ARB_IDLE && |job_req)   rr_ptr <= PW'(oh_idx(32'(pick)));
  end

  oled_arb_pick #(.N_REQ(N_REQ)) u_pick (.req(job_req), .ptr(rr_ptr), .win(pick));
`else
  oled_arb_pick #(.N_REQ(N_REQ)) u_pick (.req(job_req), .win(pick));
`endif

  // Owner let go with a byte still shifting: keep the engine fed from the shadow.
  assign hold_shadow = ~job_req[g] & in_flight;
  assign byte_live   = (in_flight | spi_send) & ~spi_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:  if (|job_req) state_nx = ARB_OWN;
      ARB_OWN:   if (!job_req[g]) state_nx = byte_live ? ARB_DRAIN : ARB_GAP;
      ARB_DRAIN: if (spi_done) state_nx = ARB_GAP;
      ARB_GAP:   state_nx = ARB_IDLE;
      default:   state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    spi_send = 1'b0;
    spi_data = 8'h00;
    spi_dc   = 1'b0;
    req_done = '0;
    case (state)
      ARB_OWN: begin
        if (hold_shadow) begin
          spi_send = 1'b1;
          spi_data = sh_data;
          spi_dc   = sh_dc;
        end else begin
          spi_send = req_send[g];
          spi_data = req_data[{g, 3'b000} +: 8];
          spi_dc   = req_dc[g];
        end
        req_done[g] = spi_done;
      end
      ARB_DRAIN: begin
        spi_send = 1'b1;
        spi_data = sh_data;
        spi_dc   = sh_dc;
      end
      default: ;
    endcase
  end

  assign busy = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      job_gnt   <= '0;
      in_flight <= 1'b0;
      sh_data   <= 8'h00;
      sh_dc     <= DC_CMD;
    end else begin
      if (state == ARB_IDLE && |job_req) job_gnt <= pick;
      else if (state_nx != ARB_OWN)      job_gnt <= '0;

      if (spi_done)                           in_flight <= 1'b0;
      else if (state == ARB_OWN && spi_send)  in_flight <= 1'b1;

      if (state == ARB_OWN && req_send[g] && !hold_shadow) begin
        sh_data <= req_data[{g, 3'b000} +: 8];
        sh_dc   <= req_dc[g];
      end
    end
  end

endmodule

// File: doc/oled_spi_arbiter.md
# oled_spi_arbiter

Shares the single OLED SPI byte engine between the display's byte-producing jobs: power-up init, screen clear, and digit/string draw. Each job requests an exclusive session, drives bytes using the engine's level-send / `send_done` protocol, and releases. The arbiter grants one session at a time so multi-byte command sequences (page/column set + data) are never interleaved. It sits between the job sequencers and the SPI byte transmitter.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters. Index 0 = init, 1 = clear, 2 = draw.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `job_req`  in  N_REQ  session request per requester; held high for the whole job
- `job_gnt`  out  N_REQ  one-hot session grant (registered)
- `req_send`  in  N_REQ  per-requester byte send; level, held until its `req_done`
- `req_data`  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
- `req_dc`  in  N_REQ  per-requester D/C# (1 = data, 0 = command)
- `req_done`  out  N_REQ  `spi_done` routed to the granted requester only
- `spi_send`  out  1  byte send to SPI engine, level
- `spi_data`  out  8  byte to SPI engine
- `spi_dc`  out  1  D/C# to panel
- `spi_done`  in  1  one-cycle pulse: current byte shifted out
- `busy`  out  1  high whenever any session is granted or draining

## Operation
- States: IDLE, OWN, DRAIN, GAP.
- IDLE: if any `job_req` bit is high, the picker selects a winner; `job_gnt` goes one-hot next edge; -> OWN. No request: stay.
- OWN: `spi_send`/`spi_data`/`spi_dc` mux combinationally from the granted requester; `req_done[g]` = `spi_done`; all other `req_done` = 0. A shadow register captures `req_data[g]`/`req_dc[g]` every cycle `req_send[g]` = 1. An in-flight flag sets on `spi_send` = 1 and clears on `spi_done`.
- OWN -> GAP when `job_req[g]` = 0 and no byte is in flight.
- OWN -> DRAIN when `job_req[g]` drops with a byte in flight (protocol violation). DRAIN holds `spi_send` = 1 with shadow data/dc; `job_gnt` = 0; `req_done` all 0. -> GAP on `spi_done`.
- GAP: exactly one cycle, `spi_send` = 0, `job_gnt` = 0, so the engine sees a send low between sessions -> IDLE.
- `req_send` from non-granted requesters is ignored. A request that arrives during OWN/DRAIN/GAP waits.
- `job_req` is sampled only in IDLE; the grant never changes mid-session.

## Timing
- Reset (async assert, sync release): state IDLE, `job_gnt` = 0, `spi_send` = 0, `spi_data` = 0, `spi_dc` = 0, `req_done` = 0, `busy` = 0, shadow = 0, in-flight = 0, round-robin pointer = N_REQ-1.
- Reset mid-byte aborts immediately; the SPI engine is reset on the same net.
- Request-to-grant latency: 1 cycle from IDLE.
- Requester send to `spi_send`: 0 cycles (combinational in OWN).
- `spi_done` to `req_done`: 0 cycles.
- Release-to-next-grant: `job_req` low at edge k -> GAP at k+1 -> IDLE at k+2 -> new grant at k+3.
- `busy` = (state != IDLE).

## Configuration
- `OLED_ARB_RR_EN` defined: round-robin. Search starts at last granted index + 1, wrapping at N_REQ-1 -> 0. The pointer updates on each grant.
- Not defined: fixed priority, lowest index wins (init > clear > draw). The pointer logic is absent.

## Structure
- Package `oled_pkg`: `N_REQ` default, `REQ_INIT`/`REQ_CLEAR`/`REQ_DRAW` index constants, arbiter state enum, D/C# encoding constants.
- Sub-module `oled_arb_pick`: combinational picker taking request vector and pointer, returning one-hot winner; round-robin logic sits under `OLED_ARB_RR_EN`.

## Test plan
- **Single request:** `job_req` = 3'b010, requester 1 sends bytes 0xB0, 0x10, 0x00, then drops request.
  - `job_gnt` = 3'b010 one cycle after request.
  - Three `spi_send` sessions appear with matching `spi_data`; `req_done[1]` pulses three times.
  - One GAP cycle follows, then `busy` = 0.
- **Simultaneous requests, fixed priority:** `job_req` = 3'b111 at the same edge.
  - Grants in order 001, 100-blocked-until-010, i.e. 001 -> 010 -> 100.
  - Each grant separated by a GAP cycle with `spi_send` = 0.
- **Simultaneous requests, `OLED_ARB_RR_EN`:** all requesters held continuously.
  - Grant order 0, 1, 2, 0.
  - After reset the first grant is index 0.
- **Non-granted traffic:** requester 2 drives `req_send` = 1, `req_data` = 0xFF while requester 0 is granted.
  - `spi_data` follows requester 0 only.
  - `req_done[2]` stays 0.
- **Drain:** granted requester drops `job_req` and `req_send` while a byte of 0x55, `dc` = 1, is in flight.
  - `spi_send` stays 1 with `spi_data` = 0x55, `spi_dc` = 1 until `spi_done`.
  - Then one GAP cycle, then IDLE.
- **Reset mid-session:** assert `reset` low during OWN.
  - All outputs are 0 in the same cycle, state is IDLE.
  - After release with `job_req` = 3'b100 held, the grant is 3'b100 one cycle later.
